// File: rtl/riscv_system_ram_port_arbiter.sv
// Shares RAM port 2 between m0 (ifetch/debug) and m1 (DMA); round-robin or fixed-priority grant.
// Latency: request granted combinationally in the address cycle, readdatavalid one cycle later.
// Backpressure: the losing requester sees waitrequest=1 and must hold its request until granted.
module riscv_system_ram_port_arbiter #(
    parameter int ADDR_WIDTH     = 13,
    parameter int DATA_WIDTH     = 32,
    parameter int BE_WIDTH       = DATA_WIDTH / 8,
    parameter int FIXED_PRIORITY = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] m0_address,
    input  logic [BE_WIDTH-1:0]   m0_byteenable,
    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [DATA_WIDTH-1:0] m0_writedata,
    output logic                  m0_waitrequest,
    output logic [DATA_WIDTH-1:0] m0_readdata,
    output logic                  m0_readdatavalid,
    input  logic [ADDR_WIDTH-1:0] m1_address,
    input  logic [BE_WIDTH-1:0]   m1_byteenable,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [DATA_WIDTH-1:0] m1_writedata,
    output logic                  m1_waitrequest,
    output logic [DATA_WIDTH-1:0] m1_readdata,
    output logic                  m1_readdatavalid,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [BE_WIDTH-1:0]   mem_byteenable,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic [DATA_WIDTH-1:0] mem_writedata,
    output logic                  mem_clken,
    input  logic [DATA_WIDTH-1:0] mem_readdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LAST0 = 2'd1,
        LAST1 = 2'd2
    } arb_state_t;

    arb_state_t state, state_nxt;
    logic       req0, req1;
    logic       grant0, grant1;
    logic       rd_accept;
    logic       rd_pending, rd_owner;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Fixed-priority mode never rotates, so the pointer stays parked in IDLE.
    always_comb begin
        state_nxt = state;
        if (FIXED_PRIORITY == 0) begin
            if (grant0) begin
                state_nxt = LAST0;
            end else if (grant1) begin
                state_nxt = LAST1;
            end
        end
    end

    // IDLE behaves like LAST1 so m0 wins the first tie. Grants are held off while in reset
    // so the RAM port is deselected immediately on an asynchronous assert.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (reset_n) begin
            if (req0 && req1) begin
                if (FIXED_PRIORITY != 0 || state != LAST0) begin
                    grant0 = 1'b1;
                end else begin
                    grant1 = 1'b1;
                end
            end else begin
                grant0 = req0;
                grant1 = req1;
            end
        end
    end

    always_comb begin
        mem_address    = grant1 ? m1_address    : m0_address;
        mem_byteenable = grant1 ? m1_byteenable : m0_byteenable;
        mem_writedata  = grant1 ? m1_writedata  : m0_writedata;
        mem_chipselect = grant0 | grant1;
        mem_write      = (grant0 & m0_write) | (grant1 & m1_write);
        mem_clken      = reset_n;
        m0_waitrequest = req0 & ~grant0;
        m1_waitrequest = req1 & ~grant1;
    end

    // read+write together is handled as a write and produces no response.
    assign rd_accept = (grant0 & m0_read & ~m0_write) | (grant1 & m1_read & ~m1_write);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_pending <= 1'b0;
            rd_owner   <= 1'b0;
        end else begin
            rd_pending <= rd_accept;
            if (rd_accept) begin
                rd_owner <= grant1;
            end
        end
    end

    assign m0_readdatavalid = rd_pending & ~rd_owner;
    assign m1_readdatavalid = rd_pending &  rd_owner;
    assign m0_readdata      = mem_readdata;
    assign m1_readdata      = mem_readdata;

endmodule

// File: tb/tb_riscv_system_ram_port_arbiter.sv
// Bench for riscv_system_ram_port_arbiter: directed vector table plus reset, read+write and
// fixed-priority sequences, with a behavioural 8192x32 RAM behind the shared port.
module tb_riscv_system_ram_port_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [12:0] m0_address, m1_address;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_writedata, m1_writedata;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic [12:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect, mem_write, mem_clken;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;

    logic        fp_m0_waitrequest, fp_m1_waitrequest;
    logic [31:0] fp_m0_readdata, fp_m1_readdata;
    logic        fp_m0_readdatavalid, fp_m1_readdatavalid;
    logic [12:0] fp_mem_address;
    logic [3:0]  fp_mem_byteenable;
    logic        fp_mem_chipselect, fp_mem_write, fp_mem_clken;
    logic [31:0] fp_mem_writedata;

    logic [31:0] ram [0:8191];

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    riscv_system_ram_port_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
        .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
        .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_clken(mem_clken), .mem_readdata(mem_readdata)
    );

    riscv_system_ram_port_arbiter #(.FIXED_PRIORITY(1)) dut_fp (
        .clk(clk), .reset_n(reset_n),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(fp_m0_waitrequest),
        .m0_readdata(fp_m0_readdata), .m0_readdatavalid(fp_m0_readdatavalid),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(fp_m1_waitrequest),
        .m1_readdata(fp_m1_readdata), .m1_readdatavalid(fp_m1_readdatavalid),
        .mem_address(fp_mem_address), .mem_byteenable(fp_mem_byteenable),
        .mem_chipselect(fp_mem_chipselect), .mem_write(fp_mem_write),
        .mem_writedata(fp_mem_writedata), .mem_clken(fp_mem_clken), .mem_readdata(32'h0)
    );

    // Behavioural RAM port: byte-enabled write, registered read.
    always @(posedge clk) begin
        if (mem_clken && mem_chipselect) begin
            if (mem_write) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_byteenable[b]) ram[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
                end
            end else begin
                mem_readdata <= ram[mem_address];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        r0, wr0, r1, wr1;
        logic [12:0] a0, a1;
        logic [31:0] wd1;
        logic [3:0]  be1;
        logic        e_w0, e_w1, e_cs, e_we;
        logic [12:0] e_addr;
        logic        e_rv0, e_rv1;
        logic [31:0] e_rd;
    } vec_t;

    vec_t vecs [15];
    int   pulses;

    initial begin
        vecs[0]  = '{1,0,0,0, 13'h0010,13'h0000, 32'h0,        4'hF, 0,0,1,0, 13'h0010, 0,0, 32'h0};
        vecs[1]  = '{0,0,0,0, 13'h0000,13'h0000, 32'h0,        4'hF, 0,0,0,0, 13'h0000, 1,0, 32'hDEADBEEF};
        vecs[2]  = '{1,0,1,0, 13'h0010,13'h1FFF, 32'h0,        4'hF, 1,0,1,0, 13'h1FFF, 0,0, 32'h0};
        vecs[3]  = '{1,0,1,0, 13'h0010,13'h1FFF, 32'h0,        4'hF, 0,1,1,0, 13'h0010, 0,1, 32'hAAAAAAAA};
        vecs[4]  = '{1,0,1,0, 13'h0010,13'h1FFF, 32'h0,        4'hF, 1,0,1,0, 13'h1FFF, 1,0, 32'hDEADBEEF};
        vecs[5]  = '{1,0,1,0, 13'h0010,13'h1FFF, 32'h0,        4'hF, 0,1,1,0, 13'h0010, 0,1, 32'hAAAAAAAA};
        vecs[6]  = '{1,0,1,0, 13'h0010,13'h1FFF, 32'h0,        4'hF, 1,0,1,0, 13'h1FFF, 1,0, 32'hDEADBEEF};
        vecs[7]  = '{1,0,1,0, 13'h0010,13'h1FFF, 32'h0,        4'hF, 0,1,1,0, 13'h0010, 0,1, 32'hAAAAAAAA};
        vecs[8]  = '{0,0,0,0, 13'h0000,13'h0000, 32'h0,        4'hF, 0,0,0,0, 13'h0000, 1,0, 32'hDEADBEEF};
        vecs[9]  = '{0,0,0,1, 13'h0000,13'h1FFF, 32'h12345678, 4'h3, 0,0,1,1, 13'h1FFF, 0,0, 32'h0};
        vecs[10] = '{1,0,0,0, 13'h1FFF,13'h0000, 32'h0,        4'hF, 0,0,1,0, 13'h1FFF, 0,0, 32'h0};
        vecs[11] = '{0,0,0,0, 13'h0000,13'h0000, 32'h0,        4'hF, 0,0,0,0, 13'h0000, 1,0, 32'hAAAA5678};
        vecs[12] = '{1,0,0,1, 13'h0020,13'h0020, 32'h11112222, 4'hF, 1,0,1,1, 13'h0020, 0,0, 32'h0};
        vecs[13] = '{1,0,0,0, 13'h0020,13'h0000, 32'h0,        4'hF, 0,0,1,0, 13'h0020, 0,0, 32'h0};
        vecs[14] = '{0,0,0,0, 13'h0000,13'h0000, 32'h0,        4'hF, 0,0,0,0, 13'h0000, 1,0, 32'h11112222};

        for (int i = 0; i < 8192; i++) ram[i] = 32'h0;
        ram[13'h0010] = 32'hDEADBEEF;
        ram[13'h1FFF] = 32'hAAAAAAAA;
        mem_readdata  = 32'h0;

        // Reset state, with m0 already requesting
        reset_n = 1'b0;
        m0_read = 1'b1; m0_write = 1'b0; m0_address = 13'h0010; m0_byteenable = 4'hF; m0_writedata = 32'h0;
        m1_read = 1'b0; m1_write = 1'b0; m1_address = 13'h0000; m1_byteenable = 4'hF; m1_writedata = 32'h0;
        #3;
        chk("reset_cs", {31'b0, mem_chipselect}, 32'd0);
        chk("reset_clken", {31'b0, mem_clken}, 32'd0);
        chk("reset_rv0", {31'b0, m0_readdatavalid}, 32'd0);
        chk("reset_rv1", {31'b0, m1_readdatavalid}, 32'd0);
        m0_read = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 15; i++) begin
            m0_read = vecs[i].r0; m0_write = vecs[i].wr0; m0_address = vecs[i].a0;
            m1_read = vecs[i].r1; m1_write = vecs[i].wr1; m1_address = vecs[i].a1;
            m1_writedata = vecs[i].wd1; m1_byteenable = vecs[i].be1;
            @(negedge clk);
            chk($sformatf("v%0d_wait0", i), {31'b0, m0_waitrequest}, {31'b0, vecs[i].e_w0});
            chk($sformatf("v%0d_wait1", i), {31'b0, m1_waitrequest}, {31'b0, vecs[i].e_w1});
            chk($sformatf("v%0d_cs", i), {31'b0, mem_chipselect}, {31'b0, vecs[i].e_cs});
            chk($sformatf("v%0d_we", i), {31'b0, mem_write}, {31'b0, vecs[i].e_we});
            chk($sformatf("v%0d_rv0", i), {31'b0, m0_readdatavalid}, {31'b0, vecs[i].e_rv0});
            chk($sformatf("v%0d_rv1", i), {31'b0, m1_readdatavalid}, {31'b0, vecs[i].e_rv1});
            if (vecs[i].e_cs) chk($sformatf("v%0d_addr", i), {19'b0, mem_address}, {19'b0, vecs[i].e_addr});
            if (vecs[i].e_we) begin
                chk($sformatf("v%0d_wdata", i), mem_writedata, vecs[i].wd1);
                chk($sformatf("v%0d_be", i), {28'b0, mem_byteenable}, {28'b0, vecs[i].be1});
            end
            if (vecs[i].e_rv0) chk($sformatf("v%0d_rd0", i), m0_readdata, vecs[i].e_rd);
            if (vecs[i].e_rv1) chk($sformatf("v%0d_rd1", i), m1_readdata, vecs[i].e_rd);
            @(posedge clk); #1;
        end

        // m0 read+write together: treated as a write with no response
        m0_read = 1'b1; m0_write = 1'b1; m0_address = 13'h0030; m0_writedata = 32'h0000FFFF;
        @(negedge clk);
        chk("rw_mem_write", {31'b0, mem_write}, 32'd1);
        chk("rw_cs", {31'b0, mem_chipselect}, 32'd1);
        @(posedge clk); #1;
        m0_read = 1'b0; m0_write = 1'b0;
        @(negedge clk);
        chk("rw_no_rv0", {31'b0, m0_readdatavalid}, 32'd0);
        chk("rw_no_rv1", {31'b0, m1_readdatavalid}, 32'd0);
        chk("rw_ram", ram[13'h0030], 32'h0000FFFF);
        @(posedge clk); #1;

        // Reset asserted in the half cycle after a granted m0 read
        m0_read = 1'b1; m0_address = 13'h0010;
        @(negedge clk);
        chk("mid_grant", {31'b0, m0_waitrequest}, 32'd0);
        @(posedge clk); #2;
        reset_n = 1'b0;
        m0_read = 1'b0;
        #1;
        chk("mid_rst_rv0", {31'b0, m0_readdatavalid}, 32'd0);
        chk("mid_rst_cs", {31'b0, mem_chipselect}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Continuous contention from reset; fixed-priority instance sees the same requests
        m0_read = 1'b1; m0_address = 13'h0010;
        m1_read = 1'b1; m1_address = 13'h1FFF;
        pulses = 0;
        for (int i = 0; i < 7; i++) begin
            if (i == 6) begin
                m0_read = 1'b0; m1_read = 1'b0;
            end
            @(negedge clk);
            if (i < 6) begin
                chk($sformatf("rr%0d_wait0", i), {31'b0, m0_waitrequest}, {31'b0, (i % 2 == 1)});
                chk($sformatf("rr%0d_wait1", i), {31'b0, m1_waitrequest}, {31'b0, (i % 2 == 0)});
                chk($sformatf("fp%0d_wait0", i), {31'b0, fp_m0_waitrequest}, 32'd0);
                chk($sformatf("fp%0d_wait1", i), {31'b0, fp_m1_waitrequest}, 32'd1);
                chk($sformatf("fp%0d_addr", i), {19'b0, fp_mem_address}, {19'b0, 13'h0010});
            end
            if (i >= 1) begin
                chk($sformatf("rr%0d_rv0", i), {31'b0, m0_readdatavalid}, {31'b0, ((i - 1) % 2 == 0)});
                chk($sformatf("rr%0d_rv1", i), {31'b0, m1_readdatavalid}, {31'b0, ((i - 1) % 2 == 1)});
                if (m0_readdatavalid) chk($sformatf("rr%0d_rd0", i), m0_readdata, 32'hDEADBEEF);
                if (m1_readdatavalid) chk($sformatf("rr%0d_rd1", i), m1_readdata, 32'hAAAA5678);
            end
            pulses += int'(m0_readdatavalid) + int'(m1_readdatavalid);
            @(posedge clk); #1;
        end
        chk("rr_pulses", pulses, 32'd6);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
